// File: rtl/apb_cmd_queue.sv
// Command FIFO and one-at-a-time sequencer in front of the APB master; in-order responses.
// Optional WAIT-state abort is enabled by defining APB_CMDQ_TIMEOUT_EN.
module apb_cmd_queue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic       PCLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic       CMD_WRITE,
    input  logic [8:0] CMD_ADDR,
    input  logic [7:0] CMD_WDATA,
    output logic       TX,
    output logic       APB_SWRITE,
    output logic [8:0] APB_SLV_PADDR,
    output logic [7:0] APB_PWDATA,
    input  logic [7:0] APB_PRDATA,
    input  logic       MST_DONE,
    output logic       RSP_VALID,
    output logic       RSP_WRITE,
    output logic [7:0] RSP_DATA,
    output logic       RSP_ERR,
    output logic       BUSY
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_param_check
        $error("apb_cmd_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
    end

    logic [17:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_state;
    logic          r_tx;
    logic          r_swrite;
    logic [8:0]    r_paddr;
    logic [7:0]    r_pwdata;
    logic          r_rsp_valid;
    logic          r_rsp_write;
    logic [7:0]    r_rsp_data;
    logic          r_rsp_err;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_tmo;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
    assign w_push  = CMD_VALID && CMD_READY;
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;

`ifdef APB_CMDQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo_cnt;

    assign w_tmo = (r_state == ST_WAIT) && !MST_DONE && (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge PCLK) begin
        if (RST) begin
            r_tmo_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ST_WAIT) && !MST_DONE) begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {CMD_WRITE, CMD_ADDR, CMD_WDATA};
        end
    end

    always_ff @(posedge PCLK) begin
        if (RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_state     <= ST_IDLE;
            r_tx        <= 1'b0;
            r_swrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_tx        <= 1'b0;
            r_rsp_valid <= 1'b0;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        {r_swrite, r_paddr, r_pwdata} <= r_mem[r_rd_ptr];
                        r_tx    <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the same cycle as the timeout takes priority.
                    if (MST_DONE || w_tmo) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= r_swrite;
                        r_rsp_err   <= !MST_DONE;
                        if (!MST_DONE) begin
                            r_rsp_data <= 8'hFF;
                        end else if (r_swrite) begin
                            r_rsp_data <= 8'h00;
                        end else begin
                            r_rsp_data <= APB_PRDATA;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign CMD_READY     = !w_full && !RST;
    assign TX            = r_tx;
    assign APB_SWRITE    = r_swrite;
    assign APB_SLV_PADDR = r_paddr;
    assign APB_PWDATA    = r_pwdata;
    assign RSP_VALID     = r_rsp_valid;
    assign RSP_WRITE     = r_rsp_write;
    assign RSP_DATA      = r_rsp_data;
    assign RSP_ERR       = r_rsp_err;
    assign BUSY          = (r_state != ST_IDLE) || !w_empty;

endmodule
